// File: rtl/cpu_seq_decoder.sv
// Registered multi-step instruction decoder: valid/ready fetch handshake, 1/2-step sequencing, registered control word.
// Optional build macro ILLEGAL_TRAP_EN: unknown opcodes raise a one-cycle illegal pulse and lock the decoder until reset.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | no instruction executing, control word idle (ps=11)
// S_EX0     | first (or only) step of the latched instruction on the outputs
// S_EX1     | second step of a 2-step instruction on the outputs
// S_WAIT_EXT| LRLI issued, waiting for its extension word from fetch

module cpu_seq_decoder #(
    parameter int         DATA_W   = 16,
    parameter logic [2:0] SP_REG   = 3'd7,
    parameter logic [2:0] LINK_REG = 3'd6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       ir_in,
    input  logic              ir_valid,
    output logic              ir_ready,
    input  logic              stall,
    output logic [2:0]        aa,
    output logic [2:0]        ba,
    output logic [2:0]        da,
    output logic              wr,
    output logic              mem_write,
    output logic [DATA_W-1:0] k,
    output logic              mux_a,
    output logic [1:0]        ps,
    output logic              busy,
    output logic              step,
    output logic              illegal
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_EX0      = 2'd1;
    localparam logic [1:0] S_EX1      = 2'd2;
    localparam logic [1:0] S_WAIT_EXT = 2'd3;

    localparam logic [6:0] OP_PUSH = 7'b1000000;
    localparam logic [6:0] OP_POP  = 7'b1000001;
    localparam logic [6:0] OP_LRLI = 7'b1000010;
    localparam logic [6:0] OP_LDR  = 7'b1000100;
    localparam logic [6:0] OP_STR  = 7'b1000101;
    localparam logic [6:0] OP_BCLR = 7'b1001000;
    localparam logic [6:0] OP_BSET = 7'b1001001;
    localparam logic [6:0] OP_JMPR = 7'b1001101;
    localparam logic [6:0] OP_CALL = 7'b1001110;

    localparam logic [1:0] PS_NEXT = 2'b00;
    localparam logic [1:0] PS_BR   = 2'b01;
    localparam logic [1:0] PS_JMP  = 2'b10;
    localparam logic [1:0] PS_HOLD = 2'b11;

    typedef struct packed {
        logic [2:0]        aa;
        logic [2:0]        ba;
        logic [2:0]        da;
        logic              wr;
        logic              mem_write;
        logic [DATA_W-1:0] k;
        logic              mux_a;
        logic [1:0]        ps;
        logic              busy;
        logic              step;
        logic              illegal;
    } ctrl_t;

    function automatic logic two_step(input logic [6:0] op);
        return op inside {OP_PUSH, OP_POP, OP_CALL, OP_LRLI};
    endfunction

    function automatic ctrl_t idle_ctrl();
        ctrl_t c;
        c    = '0;
        c.ps = PS_HOLD;
        return c;
    endfunction

    function automatic ctrl_t wait_ctrl();
        ctrl_t c;
        c      = '0;
        c.ps   = PS_HOLD;
        c.busy = 1'b1;
        c.step = 1'b1;
        return c;
    endfunction

    // Address fields not named for an op stay 0, and da is only set on writing steps.
    function automatic ctrl_t decode(input logic [15:0] w, input logic st, input logic [15:0] ext);
        ctrl_t c;
        c    = '0;
        c.ps = PS_NEXT;
        casez (w[15:9])
            7'b10100??: begin
                c.da = w[10:8];
                c.k  = DATA_W'(w[7:0]);
                c.wr = 1'b1;
            end
            7'b10101??: begin
                c.aa        = w[10:8];
                c.k         = DATA_W'(w[7:0]);
                c.mem_write = 1'b1;
            end
            7'b1011???: begin
                c.aa = w[10:8];
                c.ps = PS_BR;
            end
            OP_LDR: begin
                c.da = w[8:6];
                c.ba = w[2:0];
                c.wr = 1'b1;
            end
            OP_STR: begin
                c.aa        = w[8:6];
                c.ba        = w[2:0];
                c.mem_write = 1'b1;
            end
            OP_BSET, OP_BCLR: begin
                c.aa = w[8:6];
                c.da = w[8:6];
                c.k  = DATA_W'(1) << w[5:2];
                c.wr = 1'b1;
            end
            OP_JMPR: begin
                c.aa = w[5:3];
                c.ps = PS_JMP;
            end
            OP_PUSH: begin
                c.busy = 1'b1;
                c.step = st;
                if (!st) begin
                    c.aa        = SP_REG;
                    c.ba        = w[2:0];
                    c.mem_write = 1'b1;
                    c.ps        = PS_HOLD;
                end else begin
                    c.da = SP_REG;
                    c.k  = '1;
                    c.wr = 1'b1;
                end
            end
            OP_POP: begin
                c.busy = 1'b1;
                c.step = st;
                if (!st) begin
                    c.da = SP_REG;
                    c.k  = DATA_W'(1);
                    c.wr = 1'b1;
                    c.ps = PS_HOLD;
                end else begin
                    c.aa = SP_REG;
                    c.da = w[8:6];
                    c.wr = 1'b1;
                end
            end
            OP_CALL: begin
                c.busy = 1'b1;
                c.step = st;
                if (!st) begin
                    c.mux_a = 1'b1;
                    c.da    = LINK_REG;
                    c.wr    = 1'b1;
                    c.ps    = PS_HOLD;
                end else begin
                    c.k  = DATA_W'(w[8:0]);
                    c.ps = PS_JMP;
                end
            end
            OP_LRLI: begin
                c.busy = 1'b1;
                c.step = st;
                if (!st) begin
                    c.ps = PS_HOLD;
                end else begin
                    c.da = w[8:6];
                    c.k  = DATA_W'(ext);
                    c.wr = 1'b1;
                end
            end
            default: begin
`ifdef ILLEGAL_TRAP_EN
                c.illegal = 1'b1;
                c.ps      = PS_HOLD;
`else
                c.ps      = PS_NEXT;
`endif
            end
        endcase
        return c;
    endfunction

    logic [1:0]  state_q, state_n;
    logic [15:0] ir_q, ir_n;
    logic        trapped_q, trapped_n;
    ctrl_t       ctrl_q, ctrl_n;
    logic        cur_two, last_step, xfer;

    assign cur_two   = two_step(ir_q[15:9]);
    assign last_step = ((state_q == S_EX0) && !cur_two) || (state_q == S_EX1);
    assign ir_ready  = !rst && !stall && !trapped_q &&
                       ((state_q == S_IDLE) || (state_q == S_WAIT_EXT) || last_step);
    assign xfer      = ir_valid && ir_ready;

    always_comb begin
        state_n   = state_q;
        ir_n      = ir_q;
        trapped_n = trapped_q;
        ctrl_n    = idle_ctrl();
        if (xfer && (state_q == S_WAIT_EXT)) begin
            // The extension word feeds k directly; the latched LRLI keeps supplying da.
            state_n = S_EX1;
            ctrl_n  = decode(ir_q, 1'b1, ir_in);
        end else if (xfer) begin
            state_n   = S_EX0;
            ir_n      = ir_in;
            ctrl_n    = decode(ir_in, 1'b0, 16'h0000);
            trapped_n = ctrl_n.illegal;
        end else if ((state_q == S_EX0) && cur_two) begin
            if (ir_q[15:9] == OP_LRLI) begin
                state_n = S_WAIT_EXT;
                ctrl_n  = wait_ctrl();
            end else begin
                state_n = S_EX1;
                ctrl_n  = decode(ir_q, 1'b1, 16'h0000);
            end
        end else if (state_q == S_WAIT_EXT) begin
            ctrl_n = wait_ctrl();
        end else begin
            state_n = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ir_q      <= '0;
            trapped_q <= 1'b0;
            ctrl_q    <= idle_ctrl();
        end else if (!stall) begin
            state_q   <= state_n;
            ir_q      <= ir_n;
            trapped_q <= trapped_n;
            ctrl_q    <= ctrl_n;
        end
    end

    assign aa        = ctrl_q.aa;
    assign ba        = ctrl_q.ba;
    assign da        = ctrl_q.da;
    assign wr        = ctrl_q.wr;
    assign mem_write = ctrl_q.mem_write;
    assign k         = ctrl_q.k;
    assign mux_a     = ctrl_q.mux_a;
    // The PC is held for as long as the pipeline is frozen, whatever step is on the outputs.
    assign ps        = stall ? PS_HOLD : ctrl_q.ps;
    assign busy      = ctrl_q.busy;
    assign step      = ctrl_q.step;
    assign illegal   = ctrl_q.illegal;

endmodule

// File: tb/tb_cpu_seq_decoder.sv
// Directed bench for cpu_seq_decoder: reset, 1-step and 2-step ops, LRLI extension, stall, reset abort, unknown opcode.
// Honours ILLEGAL_TRAP_EN when it is defined for the build.

module tb_cpu_seq_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ir_in;
    logic        ir_valid;
    logic        ir_ready;
    logic        stall;
    logic [2:0]  aa, ba, da;
    logic        wr, mem_write;
    logic [15:0] k;
    logic        mux_a;
    logic [1:0]  ps;
    logic        busy, step, illegal;

    int tests = 0;
    int fails = 0;

    cpu_seq_decoder #(.DATA_W(16), .SP_REG(3'd7), .LINK_REG(3'd6)) dut (
        .clk(clk), .rst(rst), .ir_in(ir_in), .ir_valid(ir_valid), .ir_ready(ir_ready),
        .stall(stall), .aa(aa), .ba(ba), .da(da), .wr(wr), .mem_write(mem_write), .k(k),
        .mux_a(mux_a), .ps(ps), .busy(busy), .step(step), .illegal(illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; ir_valid = 1'b0; ir_in = 16'h0000;
        tick(); tick();
        tests++;
        if ({aa, ba, da, wr, mem_write, k, mux_a, ps, busy, step, illegal, ir_ready} !==
            {3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_outputs: da=%0d wr=%b k=%h ps=%b busy=%b ir_ready=%b, want zeros with ps=11",
                     da, wr, k, ps, busy, ir_ready);
        end
        rst = 1'b0;
        tick();
        tests++;
        if ({ir_ready, busy, ps} !== {1'b1, 1'b0, 2'b11}) begin
            fails++;
            $display("FAIL reset_release: ir_ready=%b busy=%b ps=%b, want 1 0 11", ir_ready, busy, ps);
        end
    endtask

    task automatic test_back_to_back();
        ir_in = 16'hA3C5; ir_valid = 1'b1;
        #1;
        tests++;
        if (ir_ready !== 1'b1) begin
            fails++; $display("FAIL b2b_ready0: ir_ready=%b want 1", ir_ready);
        end
        tick();
        tests++;
        if ({aa, ba, da, wr, mem_write, k, ps, busy} !== {3'd0, 3'd0, 3'd3, 1'b1, 1'b0, 16'h00C5, 2'b00, 1'b0}) begin
            fails++;
            $display("FAIL ldi: aa=%0d da=%0d wr=%b mw=%b k=%h ps=%b, want aa=0 da=3 wr=1 mw=0 k=00c5 ps=00",
                     aa, da, wr, mem_write, k, ps);
        end
        ir_in = 16'hAA10;
        #1;
        tests++;
        if (ir_ready !== 1'b1) begin
            fails++; $display("FAIL b2b_ready1: ir_ready=%b want 1", ir_ready);
        end
        tick();
        tests++;
        if ({aa, ba, da, wr, mem_write, k, ps} !== {3'd2, 3'd0, 3'd0, 1'b0, 1'b1, 16'h0010, 2'b00}) begin
            fails++;
            $display("FAIL sti: aa=%0d da=%0d wr=%b mw=%b k=%h ps=%b, want aa=2 da=0 wr=0 mw=1 k=0010 ps=00",
                     aa, da, wr, mem_write, k, ps);
        end
        ir_valid = 1'b0;
        tick();
        tests++;
        if ({wr, mem_write, ps, ir_ready} !== {1'b0, 1'b0, 2'b11, 1'b1}) begin
            fails++;
            $display("FAIL b2b_idle: wr=%b mw=%b ps=%b ir_ready=%b, want 0 0 11 1", wr, mem_write, ps, ir_ready);
        end
    endtask

    task automatic test_single_ops();
        // BRZ r5, JMPR r5, BSET r1 bit5, LDR r4<-[r6] issued back to back
        ir_in = 16'hB500; ir_valid = 1'b1;
        tick();
        tests++;
        if ({aa, da, wr, mem_write, ps} !== {3'd5, 3'd0, 1'b0, 1'b0, 2'b01}) begin
            fails++; $display("FAIL brz: aa=%0d wr=%b ps=%b, want aa=5 wr=0 ps=01", aa, wr, ps);
        end
        ir_in = 16'h9A28;
        tick();
        tests++;
        if ({aa, da, wr, ps} !== {3'd5, 3'd0, 1'b0, 2'b10}) begin
            fails++; $display("FAIL jmpr: aa=%0d wr=%b ps=%b, want aa=5 wr=0 ps=10", aa, wr, ps);
        end
        ir_in = 16'h9254;
        tick();
        tests++;
        if ({aa, da, k, wr, ps} !== {3'd1, 3'd1, 16'h0020, 1'b1, 2'b00}) begin
            fails++;
            $display("FAIL bset: aa=%0d da=%0d k=%h wr=%b ps=%b, want 1 1 0020 1 00", aa, da, k, wr, ps);
        end
        ir_in = 16'h8906;
        tick();
        tests++;
        if ({aa, ba, da, wr, mem_write, ps} !== {3'd0, 3'd6, 3'd4, 1'b1, 1'b0, 2'b00}) begin
            fails++;
            $display("FAIL ldr: aa=%0d ba=%0d da=%0d wr=%b ps=%b, want 0 6 4 1 00", aa, ba, da, wr, ps);
        end
        ir_valid = 1'b0;
        tick();
    endtask

    task automatic test_push_pop();
        ir_in = 16'h8005; ir_valid = 1'b1;
        tick();
        tests++;
        if ({aa, ba, da, wr, mem_write, ps, busy, step} !== {3'd7, 3'd5, 3'd0, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL push_ex0: aa=%0d ba=%0d da=%0d wr=%b mw=%b ps=%b busy=%b step=%b, want 7 5 0 0 1 11 1 0",
                     aa, ba, da, wr, mem_write, ps, busy, step);
        end
        tests++;
        if (ir_ready !== 1'b0) begin
            fails++; $display("FAIL push_ex0_ready: ir_ready=%b want 0", ir_ready);
        end
        ir_valid = 1'b0;
        tick();
        tests++;
        if ({aa, da, wr, mem_write, k, ps, busy, step, ir_ready} !==
            {3'd0, 3'd7, 1'b1, 1'b0, 16'hFFFF, 2'b00, 1'b1, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL push_ex1: aa=%0d da=%0d wr=%b k=%h ps=%b step=%b ready=%b, want 0 7 1 ffff 00 1 1",
                     aa, da, wr, k, ps, step, ir_ready);
        end
        ir_in = 16'h82C0; ir_valid = 1'b1;
        tick();
        tests++;
        if ({aa, da, wr, k, ps, busy} !== {3'd0, 3'd7, 1'b1, 16'h0001, 2'b11, 1'b1}) begin
            fails++;
            $display("FAIL pop_ex0: aa=%0d da=%0d wr=%b k=%h ps=%b, want 0 7 1 0001 11", aa, da, wr, k, ps);
        end
        ir_valid = 1'b0;
        tick();
        tests++;
        if ({aa, da, wr, k, ps} !== {3'd7, 3'd3, 1'b1, 16'h0000, 2'b00}) begin
            fails++;
            $display("FAIL pop_ex1: aa=%0d da=%0d wr=%b k=%h ps=%b, want 7 3 1 0000 00", aa, da, wr, k, ps);
        end
        tick();
        tests++;
        if ({busy, wr} !== 2'b00) begin
            fails++; $display("FAIL pop_done: busy=%b wr=%b want 0 0", busy, wr);
        end
    endtask

    task automatic test_lrli_stall();
        ir_in = 16'h8480; ir_valid = 1'b1;
        tick();
        tests++;
        if ({wr, mem_write, da, ps, busy, ir_ready} !== {1'b0, 1'b0, 3'd0, 2'b11, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL lrli_ex0: wr=%b mw=%b da=%0d ps=%b busy=%b ready=%b, want 0 0 0 11 1 0",
                     wr, mem_write, da, ps, busy, ir_ready);
        end
        ir_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if ({wr, mem_write, ps, ir_ready} !== {1'b0, 1'b0, 2'b11, 1'b1}) begin
                fails++;
                $display("FAIL lrli_wait%0d: wr=%b mw=%b ps=%b ready=%b, want 0 0 11 1", i, wr, mem_write, ps, ir_ready);
            end
        end
        ir_in = 16'h1234; ir_valid = 1'b1;
        tick();
        tests++;
        if ({da, k, wr, mem_write, ps} !== {3'd2, 16'h1234, 1'b1, 1'b0, 2'b00}) begin
            fails++;
            $display("FAIL lrli_ex1: da=%0d k=%h wr=%b ps=%b, want 2 1234 1 00", da, k, wr, ps);
        end
        ir_valid = 1'b0; stall = 1'b1;
        #1;
        tests++;
        if (ir_ready !== 1'b0) begin
            fails++; $display("FAIL stall_ready: ir_ready=%b want 0", ir_ready);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            tests++;
            if ({da, k, wr, ps, busy, step} !== {3'd2, 16'h1234, 1'b1, 2'b11, 1'b1, 1'b1}) begin
                fails++;
                $display("FAIL stall_hold%0d: da=%0d k=%h wr=%b ps=%b, want 2 1234 1 11", i, da, k, wr, ps);
            end
        end
        stall = 1'b0;
        tick();
        tests++;
        if ({wr, busy, ps} !== {1'b0, 1'b0, 2'b11}) begin
            fails++; $display("FAIL lrli_done: wr=%b busy=%b ps=%b, want 0 0 11", wr, busy, ps);
        end
    endtask

    task automatic test_call_rst_abort();
        ir_in = 16'h9C55; ir_valid = 1'b1;
        tick();
        tests++;
        if ({mux_a, da, wr, ps, busy, step} !== {1'b1, 3'd6, 1'b1, 2'b11, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL call_ex0: mux_a=%b da=%0d wr=%b ps=%b busy=%b, want 1 6 1 11 1", mux_a, da, wr, ps, busy);
        end
        ir_valid = 1'b0;
        tick();
        tests++;
        if ({mux_a, da, wr, k, ps, step} !== {1'b0, 3'd0, 1'b0, 16'h0055, 2'b10, 1'b1}) begin
            fails++;
            $display("FAIL call_ex1: mux_a=%b da=%0d wr=%b k=%h ps=%b, want 0 0 0 0055 10", mux_a, da, wr, k, ps);
        end
        tick();
        ir_valid = 1'b1;
        tick();
        tests++;
        if ({mux_a, busy} !== 2'b11) begin
            fails++; $display("FAIL call2_ex0: mux_a=%b busy=%b want 1 1", mux_a, busy);
        end
        ir_valid = 1'b0; rst = 1'b1;
        tick();
        tests++;
        if ({mux_a, da, wr, k, busy, step, ps} !== {1'b0, 3'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 2'b11}) begin
            fails++;
            $display("FAIL rst_abort: mux_a=%b da=%0d wr=%b k=%h busy=%b ps=%b, want 0 0 0 0000 0 11",
                     mux_a, da, wr, k, busy, ps);
        end
        rst = 1'b0;
        #1;
        tests++;
        if (ir_ready !== 1'b1) begin
            fails++; $display("FAIL rst_abort_ready: ir_ready=%b want 1", ir_ready);
        end
        tick();
    endtask

    task automatic test_illegal();
        ir_in = 16'hFE00; ir_valid = 1'b1;
        tick();
`ifdef ILLEGAL_TRAP_EN
        tests++;
        if ({illegal, ps, wr, mem_write, ir_ready} !== {1'b1, 2'b11, 1'b0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL trap_pulse: illegal=%b ps=%b wr=%b ready=%b, want 1 11 0 0", illegal, ps, wr, ir_ready);
        end
        tick();
        tests++;
        if ({illegal, ir_ready, wr} !== 3'b000) begin
            fails++; $display("FAIL trap_stuck: illegal=%b ready=%b wr=%b, want 0 0 0", illegal, ir_ready, wr);
        end
`else
        tests++;
        if ({illegal, ps, wr, mem_write, ir_ready} !== {1'b0, 2'b00, 1'b0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL unknown_nop: illegal=%b ps=%b wr=%b ready=%b, want 0 00 0 1", illegal, ps, wr, ir_ready);
        end
`endif
        ir_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_single_ops();
        test_push_pop();
        test_lrli_stall();
        test_call_rst_abort();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
